// File: rtl/des_key_schedule_dec.sv
//==============================================================================
// des_key_schedule_dec : DES decryption key schedule, emits K16..K1 one per cycle
// Optional macro DES_KEYSCHED_HOLD_EN adds an 'advance' stall input.  Rev 1.0
//==============================================================================
`default_nettype none

module des_key_schedule_dec (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [0:63] key_in,
`ifdef DES_KEYSCHED_HOLD_EN
  input  logic        advance,
`endif
  output logic        ready,
  output logic        subkey_valid,
  output logic [0:47] subkey,
  output logic [3:0]  rnd,
  output logic        done
);

  localparam int unsigned c_pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned c_pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] r;
    for (int i = 0; i < 56; i++) r[i] = k[c_pc1[i] - 1];
    return r;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] r;
    for (int i = 0; i < 48; i++) r[i] = cd[c_pc2[i] - 1];
    return r;
  endfunction

  function automatic logic [0:27] rotr(input logic [0:27] x, input logic by_one);
    return by_one ? {x[27], x[0:26]} : {x[26:27], x[0:25]};
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [0:27] c_q, c_d, d_q, d_d;
  logic        done_q, done_d;
  logic        w_adv;
  logic        w_one;
  logic [0:55] w_pc1;

`ifdef DES_KEYSCHED_HOLD_EN
  assign w_adv = advance;
`else
  assign w_adv = 1'b1;
`endif

  // Decryption rounds 2, 9 and 16 undo the single-bit encryption shifts.
  assign w_one = (cnt_q == 4'd0) || (cnt_q == 4'd7) || (cnt_q == 4'd14);
  assign w_pc1 = pc1(key_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      c_q     <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      d_q     <= d_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    d_d     = d_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          c_d     = w_pc1[0:27];
          d_d     = w_pc1[28:55];
          cnt_d   = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (w_adv) begin
          if (cnt_q == 4'd15) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
            c_d   = rotr(c_q, w_one);
            d_d   = rotr(d_q, w_one);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready        = (state_q == IDLE);
  assign subkey_valid = (state_q == RUN);
  assign rnd          = cnt_q;
  assign subkey       = pc2({c_q, d_q});
  assign done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_des_key_schedule_dec.sv
// Testbench for des_key_schedule_dec: random keys scored against an encryption-order
// key schedule model; monitor pops expectations as the DUT presents subkeys/done.
`default_nettype none

module tb_des_key_schedule_dec;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam logic [63:0] KAT = 64'h133457799BBCDFF1;

  logic        clk, rst, start, adv;
  logic [63:0] key;
  logic        ready, subkey_valid, done;
  logic [47:0] subkey;
  logic [3:0]  rnd;

  typedef struct { bit is_done; logic [3:0] r; logic [47:0] k; } exp_t;
  exp_t q[$];
  exp_t last;
  int   checks = 0, errors = 0;
  int   model_cnt = 0;
  bit   accepted;
  bit   prev_valid = 0;

  des_key_schedule_dec dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key),
`ifdef DES_KEYSCHED_HOLD_EN
    .advance(adv),
`endif
    .ready(ready), .subkey_valid(subkey_valid), .subkey(subkey), .rnd(rnd), .done(done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Encryption-order subkey Kn: left-rotate C/D by the standard shift table n times.
  function automatic logic [47:0] enc_subkey(input logic [63:0] k, input int n);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] r;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = k[64-PC1[i]];
      d[27-i] = k[64-PC1[28+i]];
    end
    for (int j = 1; j <= n; j++) begin
      int s;
      s = (j == 1 || j == 2 || j == 9 || j == 16) ? 1 : 2;
      c = (c << s) | (c >> (28 - s));
      d = (d << s) | (d >> (28 - s));
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  task automatic push_run(input logic [63:0] k);
    exp_t e;
    for (int r = 0; r < 16; r++) begin
      e.is_done = 0;
      e.r = 4'(r);
      e.k = enc_subkey(k, 16 - r);
      q.push_back(e);
    end
    e.is_done = 1; e.r = 0; e.k = 0;
    q.push_back(e);
  endtask

  task automatic cycle(input bit st, input logic [63:0] k, input bit a);
    @(negedge clk);
    start = st; key = k; adv = a;
    accepted = 0;
    if (model_cnt == 0) begin
      if (st) begin
        push_run(k);
        model_cnt = 16;
        accepted = 1;
      end
    end else if (a) begin
      model_cnt--;
    end
    @(posedge clk); #2;
  endtask

  function automatic logic [63:0] rkey();
    return {$urandom, $urandom};
  endfunction

  // Monitor: consumes one expectation per fresh subkey and per done pulse.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (subkey_valid) begin
        if (prev_valid && !adv) begin
          chk(subkey == last.k, "hold_subkey", 64'(subkey), 64'(last.k));
          chk(rnd == last.r, "hold_rnd", 64'(rnd), 64'(last.r));
        end else if (q.size() == 0 || q[0].is_done) begin
          chk(0, "unexpected_subkey", 64'(subkey), 64'(0));
        end else begin
          last = q.pop_front();
          chk(subkey == last.k, "subkey", 64'(subkey), 64'(last.k));
          chk(rnd == last.r, "rnd", 64'(rnd), 64'(last.r));
        end
      end
      if (done) begin
        if (q.size() == 0 || !q[0].is_done) chk(0, "unexpected_done", 64'(done), 64'(0));
        else begin
          void'(q.pop_front());
          chk(1, "done", 64'(done), 64'(1));
        end
      end
      prev_valid = subkey_valid;
    end
  end

  initial begin
    rst = 1; start = 0; adv = 1; key = 0;
    // Reset with random inputs
    repeat (3) begin
      @(negedge clk);
      start = 1'($urandom); key = rkey();
    end
    #1;
    chk(ready == 1, "rst_ready", 64'(ready), 64'(1));
    chk(subkey_valid == 0, "rst_valid", 64'(subkey_valid), 64'(0));
    chk(subkey == 0, "rst_subkey", 64'(subkey), 64'(0));
    chk(done == 0, "rst_done", 64'(done), 64'(0));
    chk(rnd == 0, "rst_rnd", 64'(rnd), 64'(0));
    @(negedge clk);
    rst = 0; start = 0;
    cycle(0, rkey(), 1);
    chk(ready == 1 && subkey_valid == 0 && done == 0 && subkey == 0, "post_rst_idle",
        {ready, subkey_valid, done, subkey}, {3'b100, 48'h0});

    // Known-answer run with direct checks
    cycle(1, KAT, 1);
    chk(subkey == 48'hCB3D8B0E17F5 && rnd == 0, "kat_rnd0", 64'(subkey), 64'hCB3D8B0E17F5);
    cycle(0, rkey(), 1);
    chk(subkey == 48'hBF918D3D3F0A && rnd == 1, "kat_rnd1", 64'(subkey), 64'hBF918D3D3F0A);
    repeat (12) cycle(0, rkey(), 1);
    cycle(0, rkey(), 1);
    chk(subkey == 48'h79AED9DBC9E5 && rnd == 14, "kat_rnd14", 64'(subkey), 64'h79AED9DBC9E5);
    cycle(0, rkey(), 1);
    chk(subkey == 48'h1B02EFFC7072 && rnd == 15, "kat_rnd15", 64'(subkey), 64'h1B02EFFC7072);
    cycle(0, rkey(), 1);
    chk(done == 1 && ready == 1 && subkey_valid == 0, "kat_done_t16",
        {done, ready, subkey_valid}, 3'b110);
    cycle(0, rkey(), 1);

    // Busy rejection: key A, then start held with key B from T5
    begin
      logic [63:0] ka, kb;
      ka = rkey(); kb = rkey();
      cycle(1, ka, 1);
      repeat (4) cycle(0, rkey(), 1);
      for (int i = 0; i < 40; i++) begin
        cycle(1, kb, 1);
        if (accepted) break;
      end
      cycle(0, rkey(), 1);
    end

    // Random keys, start sometimes held with changing key_in (back-to-back)
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 40; i++) begin
        cycle(1, rkey(), 1);
        if (accepted) break;
      end
      repeat ($urandom_range(0, 2)) cycle(0, rkey(), 1);
    end
    for (int i = 0; i < 40 && q.size() > 0; i++) cycle(0, rkey(), 1);
    chk(q.size() == 0, "drain_random", 64'(q.size()), 64'(0));

    // Reset at T7 of a running schedule
    cycle(1, rkey(), 1);
    repeat (7) cycle(0, rkey(), 1);
    #1 rst = 1;
    q.delete();
    model_cnt = 0;
    #1;
    chk(ready == 1 && subkey_valid == 0 && done == 0 && subkey == 0 && rnd == 0, "midrun_rst",
        {ready, subkey_valid, done, rnd, subkey}, {3'b100, 4'h0, 48'h0});
    @(negedge clk);
    rst = 0;
    repeat (20) cycle(0, rkey(), 1);
    cycle(1, KAT, 1);
    chk(subkey == 48'hCB3D8B0E17F5 && rnd == 0, "restart_rnd0", 64'(subkey), 64'hCB3D8B0E17F5);
    for (int i = 0; i < 40 && q.size() > 0; i++) cycle(0, rkey(), 1);
    chk(q.size() == 0, "drain_restart", 64'(q.size()), 64'(0));

`ifdef DES_KEYSCHED_HOLD_EN
    // Stall three cycles at rnd 4; done should land three cycles late
    cycle(1, KAT, 0);
    repeat (4) cycle(0, rkey(), 1);
    repeat (3) begin
      cycle(0, rkey(), 0);
      chk(rnd == 4 && subkey == enc_subkey(KAT, 12), "hold_rnd4", 64'(subkey), 64'(enc_subkey(KAT, 12)));
    end
    repeat (11) cycle(0, rkey(), 1);
    chk(done == 0 && rnd == 15, "hold_no_early_done", {done, rnd}, {1'b0, 4'hF});
    cycle(0, rkey(), 1);
    chk(done == 1, "hold_done_late", 64'(done), 64'(1));
    for (int i = 0; i < 40 && q.size() > 0; i++) cycle(0, rkey(), 1);
    chk(q.size() == 0, "drain_hold", 64'(q.size()), 64'(0));
`endif

    repeat (3) cycle(0, rkey(), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/des_key_schedule_dec.md
# des_key_schedule_dec

Decryption-direction DES key schedule. The block loads a 64-bit key, applies PC-1, and emits the 16 round subkeys in reverse order (K16 first, K1 last), one per cycle. It uses right rotations of the C/D halves. It sits beside the encryption key control/shift path and feeds the round datapath when the core runs in decrypt mode.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request to begin a schedule; sampled only while `ready`=1
- `key_in`  in  [0:63]  DES key; bit 0 = DES bit 1 (MSB); parity bits ignored
- `ready`  out  1  idle, able to accept `start`
- `subkey_valid`  out  1  `subkey` holds a valid round key this cycle
- `subkey`  out  [0:47]  PC-2(C,D); bit 0 = DES bit 1
- `rnd`  out  [3:0]  decryption round index 0..15; `subkey` = K(16-rnd)
- `done`  out  1  one-cycle pulse on the cycle after the last subkey

## Operation
- State: 2-state FSM IDLE/RUN, a 4-bit round counter `cnt`, and a 56-bit register C[0:27], D[0:27].
- IDLE
  - `ready`=1 and `subkey_valid`=0.
  - When `start`=1 at an edge: {C,D} <= PC-1(`key_in`), `cnt` <= 0, go to RUN.
- RUN
  - `ready`=0 and `subkey_valid`=1.
  - `rnd`=`cnt`; `subkey`=PC-2({C,D}), combinational from the registers.
- Rotation between decryption rounds r (1-based = `cnt`+1) and r+1:
  - {C,D} rotate right independently by s(r+1).
  - s(1)=0, s(2)=s(9)=s(16)=1, all others 2.
  - Round 1 uses PC-1 output unrotated, because C16=C0 and D16=D0.
- At `cnt`=15: go to IDLE, `done`=1 for the next cycle, `cnt` <= 0. {C,D} is not required to hold any particular value afterwards.
- `start` while in RUN is ignored; there is no queueing.
- `key_in` is sampled only on the accepting edge. Later changes have no effect on the running schedule.

## Timing
- Reset values: `ready`=1, `subkey_valid`=0, `done`=0, `rnd`=0, `subkey`=PC-2(0)=0; {C,D}=0; FSM=IDLE.
- Latency: the `start` edge is T0. K16 is valid from T0 to T1, and K(16-n) from Tn to Tn+1.
- `subkey_valid` is high for exactly 16 consecutive cycles.
- `done` is high from T16 to T17, with `ready`=1 in the same cycle.
- A new `start` is accepted at T16 at the earliest.
- Back-to-back runs give a single-cycle gap in `subkey_valid`.
- Reset asserted mid-RUN:
  - All outputs return to their reset values immediately (asynchronously).
  - No `done` pulse is produced.
- `start` held high continuously: a new schedule begins every 17 cycles.

## Configuration
- Macro: `DES_KEYSCHED_HOLD_EN`.
- Defined:
  - Adds input `advance` (1 bit).
  - In RUN, `cnt`, the rotation and the RUN→IDLE exit occur only on edges where `advance`=1.
  - Otherwise `subkey`/`rnd` hold and `subkey_valid` stays 1.
  - The accepting `start` edge does not require `advance`.
- Undefined:
  - No `advance` port.
  - Behaves as if `advance`=1 always, exactly per Timing above.

## Test plan
- Reset check: `rst`=1 with random inputs → `ready`=1, `subkey_valid`=0, `subkey`=0, `done`=0. Deassert `rst` with `start`=0 → outputs unchanged.
- Known-answer test: `key_in`=0x133457799BBCDFF1, pulse `start`. Required subkeys:
  - rnd 0: 0xCB3D8B0E17F5
  - rnd 1: 0xBF918D3D3F0A
  - rnd 14: 0x79AED9DBC9E5
  - rnd 15: 0x1B02EFFC7072
  - `done` at T16.
- Full cross-check: 16 random keys. Each emitted `subkey` equals the encryption-schedule model's K(16-`rnd`). `subkey_valid` is 1 for exactly 16 cycles.
- Busy rejection: pulse `start` with key A, then assert `start` with key B at T5 → sequence still matches key A. Key B is accepted only if `start` is still high at T16.
- Reset mid-run: assert `rst` at T7 → outputs go to reset values in the same cycle and no `done` pulse. Restart with key 0x133457799BBCDFF1 → rnd 0 = 0xCB3D8B0E17F5.
- With `DES_KEYSCHED_HOLD_EN`: known-answer key, `advance`=0 for 3 cycles at rnd 4 → `subkey`/`rnd` frozen at rnd 4. The full sequence still matches and `done` fires 3 cycles late.
